// File: rtl/bbox_overlay.sv
// bbox_overlay: draws detector bounding boxes onto a pass-through video stream.
//
// Boxes arriving on bbox_* are collected per detection pass. They are snapshotted on
// done and promoted to the display bank at the next vsync rising edge. Rectangle
// outlines are then overlaid on the video, and the video is delayed by 2 cycles.
//
// Optional feature macro: BBOX_OVERLAY_BLEND_EN
//   defined   -> hit pixels are a 50% blend of pixel and BOX_COLOR
//   undefined -> hit pixels are replaced by BOX_COLOR
//
// Ports:
//   clk, reset                   pixel clock, synchronous active-high reset
//   de, hsync, vsync, r, g, b    input video (vsync active-high)
//   bbox_valid, bbox_*           one inclusive box per valid cycle
//   done                         pulse ending a detection pass
//   de_out .. b_out              overlaid video, 2-cycle latency
//   box_count                    boxes in the display bank
//   overflow                     sticky, a box was dropped
module bbox_overlay #(
    parameter int unsigned IMAGE_WIDTH    = 1280,
    parameter int unsigned IMAGE_HEIGHT   = 720,
    parameter int unsigned MAX_BOXES      = 8,
    parameter int unsigned LINE_THICKNESS = 2,
    parameter logic [23:0] BOX_COLOR      = 24'h00FF00
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               de,
    input  logic                               hsync,
    input  logic                               vsync,
    input  logic [7:0]                         r,
    input  logic [7:0]                         g,
    input  logic [7:0]                         b,
    input  logic                               bbox_valid,
    input  logic [15:0]                        bbox_x_start,
    input  logic [15:0]                        bbox_y_start,
    input  logic [15:0]                        bbox_x_end,
    input  logic [15:0]                        bbox_y_end,
    input  logic                               done,
    output logic                               de_out,
    output logic                               hsync_out,
    output logic                               vsync_out,
    output logic [7:0]                         r_out,
    output logic [7:0]                         g_out,
    output logic [7:0]                         b_out,
    output logic [$clog2(MAX_BOXES+1)-1:0]     box_count,
    output logic                               overflow
);

    localparam int unsigned CntW = $clog2(MAX_BOXES + 1);

    typedef struct packed {
        logic [15:0] xs;
        logic [15:0] ys;
        logic [15:0] xe;
        logic [15:0] ye;
    } box_t;

    box_t                 collect_q [MAX_BOXES];
    box_t                 collect_d [MAX_BOXES];
    box_t                 ready_q   [MAX_BOXES];
    box_t                 disp_q    [MAX_BOXES];
    logic [CntW-1:0]      wr_cnt_q, wr_cnt_d, ready_cnt_q;
    logic                 ready_flag_q, draw_en_q;
    logic [15:0]          x_cnt_q, y_cnt_q;
    logic                 wr_free, wr_en, frame_start, in_frame;
    logic [MAX_BOXES-1:0] hit, hit_q;
    logic                 p1_de_q, p1_hsync_q, p1_vsync_q;
    logic [23:0]          p1_pix_q, hit_pix;

    // 17-bit compares so xs+T / x+T never wrap.
    function automatic logic box_hit(input box_t bx, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] xs, ys, xe, ye, px, py, t;
        xs = {1'b0, bx.xs};
        ys = {1'b0, bx.ys};
        xe = {1'b0, bx.xe};
        ye = {1'b0, bx.ye};
        px = {1'b0, x};
        py = {1'b0, y};
        t  = 17'(LINE_THICKNESS);
        return (xs <= xe) && (ys <= ye) && (xs <= px) && (px <= xe) && (ys <= py) && (py <= ye)
            && ((px < xs + t) || (px + t > xe) || (py < ys + t) || (py + t > ye));
    endfunction

    // p1_vsync_q / p1_de_q double as the edge-detect copies of vsync / de.
    assign frame_start = vsync & ~p1_vsync_q;
    assign wr_free     = wr_cnt_q < CntW'(MAX_BOXES);
    assign wr_en       = bbox_valid & wr_free;
    assign wr_cnt_d    = wr_cnt_q + CntW'(wr_en);
    assign in_frame    = (x_cnt_q < 16'(IMAGE_WIDTH)) && (y_cnt_q < 16'(IMAGE_HEIGHT));

    always_comb begin
        for (int i = 0; i < int'(MAX_BOXES); i++) begin
            collect_d[i] = collect_q[i];
            if (wr_en && (wr_cnt_q == CntW'(i))) begin
                collect_d[i] = {bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end};
            end
            hit[i] = draw_en_q && in_frame && (CntW'(i) < box_count)
                  && box_hit(disp_q[i], x_cnt_q, y_cnt_q);
        end
    end

    // Box banks: collect -> ready on done, ready -> display on frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MAX_BOXES); i++) begin
                collect_q[i] <= '0;
                ready_q[i]   <= '0;
                disp_q[i]    <= '0;
            end
            wr_cnt_q     <= '0;
            ready_cnt_q  <= '0;
            ready_flag_q <= 1'b0;
            box_count    <= '0;
            overflow     <= 1'b0;
            draw_en_q    <= 1'b0;
        end else begin
            collect_q <= collect_d;
            overflow  <= overflow | (bbox_valid & ~wr_free);
            draw_en_q <= draw_en_q | frame_start;
            // Swap reads the pre-edge ready bank, so a coincident done stays pending.
            if (frame_start && ready_flag_q) begin
                disp_q    <= ready_q;
                box_count <= ready_cnt_q;
            end
            if (done) begin
                ready_q      <= collect_d;
                ready_cnt_q  <= wr_cnt_d;
                ready_flag_q <= 1'b1;
                wr_cnt_q     <= '0;
            end else begin
                wr_cnt_q <= wr_cnt_d;
                if (frame_start) begin
                    ready_flag_q <= 1'b0;
                end
            end
        end
    end

    // Pixel position of the current input sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else if (frame_start) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
        end else if (de) begin
            x_cnt_q <= x_cnt_q + 16'd1;
        end else if (p1_de_q) begin
            x_cnt_q <= '0;
            y_cnt_q <= y_cnt_q + 16'd1;
        end
    end

`ifdef BBOX_OVERLAY_BLEND_EN
    always_comb begin
        hit_pix = {(p1_pix_q[23:16] >> 1) + (BOX_COLOR[23:16] >> 1),
                   (p1_pix_q[15:8]  >> 1) + (BOX_COLOR[15:8]  >> 1),
                   (p1_pix_q[7:0]   >> 1) + (BOX_COLOR[7:0]   >> 1)};
    end
`else
    assign hit_pix = BOX_COLOR;
`endif

    // Stage 1: hits and input video; stage 2: merge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q      <= '0;
            p1_de_q    <= 1'b0;
            p1_hsync_q <= 1'b0;
            p1_vsync_q <= 1'b0;
            p1_pix_q   <= '0;
            de_out     <= 1'b0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
        end else begin
            hit_q      <= hit;
            p1_de_q    <= de;
            p1_hsync_q <= hsync;
            p1_vsync_q <= vsync;
            p1_pix_q   <= {r, g, b};
            de_out     <= p1_de_q;
            hsync_out  <= p1_hsync_q;
            vsync_out  <= p1_vsync_q;
            {r_out, g_out, b_out} <= ((|hit_q) && p1_de_q) ? hit_pix : p1_pix_q;
        end
    end

endmodule

// File: tb/tb_bbox_overlay.sv
// tb_bbox_overlay: directed self-checking bench for bbox_overlay (default build).
// Source pixels encode their position as {x, y, 8'h5A}, so every output pixel is
// either that pattern or the box colour. Output frames are captured into pixbuf.
module tb_bbox_overlay;

    localparam logic [23:0] BoxC = 24'h00FF00;

    logic        clk = 1'b0;
    logic        reset, de, hsync, vsync, bbox_valid, done;
    logic [7:0]  r, g, b;
    logic [15:0] bbox_x_start, bbox_y_start, bbox_x_end, bbox_y_end;
    logic        de_out, hsync_out, vsync_out, overflow;
    logic [7:0]  r_out, g_out, b_out;
    logic [3:0]  box_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bbox_overlay #(
        .MAX_BOXES      (8),
        .LINE_THICKNESS (2),
        .BOX_COLOR      (BoxC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .r            (r),
        .g            (g),
        .b            (b),
        .bbox_valid   (bbox_valid),
        .bbox_x_start (bbox_x_start),
        .bbox_y_start (bbox_y_start),
        .bbox_x_end   (bbox_x_end),
        .bbox_y_end   (bbox_y_end),
        .done         (done),
        .de_out       (de_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .r_out        (r_out),
        .g_out        (g_out),
        .b_out        (b_out),
        .box_count    (box_count),
        .overflow     (overflow)
    );

    // Output frame capture, positions decoded from the output timing.
    logic [23:0] pixbuf [0:159][0:255];
    int          mx = 0;
    int          my = 0;
    logic        mon_de_q = 1'b0;
    logic        mon_vs_q = 1'b0;

    always @(negedge clk) begin
        mon_de_q <= de_out;
        mon_vs_q <= vsync_out;
        if (vsync_out && !mon_vs_q) begin
            mx <= 0;
            my <= 0;
        end else if (de_out) begin
            if (mx >= 0 && mx < 256 && my >= 0 && my < 160) pixbuf[my][mx] <= {r_out, g_out, b_out};
            mx <= mx + 1;
        end else if (mon_de_q) begin
            mx <= 0;
            my <= my + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] src_px(input int x, input int y);
        return {8'(x), 8'(y), 8'h5A};
    endfunction

    task automatic check_px(input string tag, input int x, input int y, input bit is_hit);
        logic [23:0] exp;
        exp = is_hit ? BoxC : src_px(x, y);
        check_eq(tag, {8'h00, pixbuf[y][x]}, {8'h00, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        r = 8'h00; g = 8'h00; b = 8'h00;
        bbox_valid = 1'b0; done = 1'b0;
        bbox_x_start = '0; bbox_y_start = '0; bbox_x_end = '0; bbox_y_end = '0;
    endtask

    task automatic send_box(input int xs, input int ys, input int xe, input int ye);
        tick();
        bbox_valid = 1'b1;
        bbox_x_start = 16'(xs); bbox_y_start = 16'(ys);
        bbox_x_end   = 16'(xe); bbox_y_end   = 16'(ye);
        tick();
        bbox_valid = 1'b0;
    endtask

    task automatic pulse_done();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // One frame: vsync pulse (optionally with done on its rising cycle), then lines.
    task automatic drive_frame(input int nlines, input int width, input bit done_at_vs);
        tick(); vsync = 1'b1; done = done_at_vs;
        tick(); done = 1'b0;
        tick(); vsync = 1'b0;
        repeat (3) tick();
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < width; x++) begin
                tick();
                de = 1'b1; r = 8'(x); g = 8'(y); b = 8'h5A;
            end
            tick();
            de = 1'b0; r = 8'h00; g = 8'h00; b = 8'h00; hsync = 1'b1;
            repeat (2) tick();
            hsync = 1'b0;
            repeat (2) tick();
        end
        repeat (4) tick();
    endtask

    logic [29:0] hist [0:63];

    initial begin
        #5ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with live-looking inputs: everything must read 0.
        idle_inputs();
        reset = 1'b1;
        de = 1'b1; vsync = 1'b1; hsync = 1'b1; r = 8'hAA; g = 8'h55; b = 8'hC3;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_timing", {29'h0, de_out, hsync_out, vsync_out}, 32'h0);
        check_eq("rst_pix", {8'h00, r_out, g_out, b_out}, 32'h0);
        check_eq("rst_count", 32'(box_count), 32'h0);
        check_eq("rst_ovf", {31'h0, overflow}, 32'h0);
        tick();
        idle_inputs();
        reset = 1'b0;
        repeat (2) tick();

        // Pass-through with no boxes.
        for (int i = 0; i < 24; i++) begin
            tick();
            {de, hsync, vsync, r, g, b} = 27'($urandom);
            hist[i] = {3'b000, de, hsync, vsync, r, g, b};
            @(negedge clk);
            if (i >= 2) begin
                check_eq("passthru", {5'h0, de_out, hsync_out, vsync_out, r_out, g_out, b_out},
                         {2'b00, hist[i-2]});
            end
        end
        check_eq("pt_count", 32'(box_count), 32'h0);
        tick();
        idle_inputs();
        repeat (3) tick();

        // Single box, outline T=2.
        send_box(100, 50, 199, 149);
        pulse_done();
        check_eq("cnt_pre_swap", 32'(box_count), 32'h0);
        drive_frame(151, 204, 1'b0);
        check_eq("cnt_box1", 32'(box_count), 32'h1);
        check_px("b1_100_50", 100, 50, 1'b1);
        check_px("b1_101_51", 101, 51, 1'b1);
        check_px("b1_102_52", 102, 52, 1'b0);
        check_px("b1_199_100", 199, 100, 1'b1);
        check_px("b1_150_100", 150, 100, 1'b0);
        check_px("b1_99_50", 99, 50, 1'b0);
        check_px("b1_200_149", 200, 149, 1'b0);
        check_px("b1_199_149", 199, 149, 1'b1);
        check_px("b1_120_149", 120, 149, 1'b1);

        // Invalid box still counts, draws nothing.
        send_box(300, 10, 200, 20);
        pulse_done();
        drive_frame(24, 48, 1'b0);
        check_eq("cnt_invalid", 32'(box_count), 32'h1);
        check_px("inv_10_10", 10, 10, 1'b0);
        check_px("inv_47_15", 47, 15, 1'b0);
        check_eq("ovf_before", {31'h0, overflow}, 32'h0);

        // Ten 3x3 boxes: only the first eight land.
        for (int i = 0; i < 10; i++) send_box(4 * i, 2, 4 * i + 2, 4);
        pulse_done();
        drive_frame(8, 48, 1'b0);
        check_eq("cnt_ovf", 32'(box_count), 32'h8);
        check_eq("ovf_set", {31'h0, overflow}, 32'h1);
        check_px("ov_1_3", 1, 3, 1'b1);
        check_px("ov_29_3", 29, 3, 1'b1);
        check_px("ov_30_4", 30, 4, 1'b1);
        check_px("ov_gap_3_3", 3, 3, 1'b0);
        check_px("ov_box9", 33, 3, 1'b0);
        check_px("ov_box10", 37, 3, 1'b0);
        check_px("ov_below", 1, 6, 1'b0);

        // Pass A pending; pass B's done lands on the vsync rise.
        send_box(2, 2, 8, 8);
        pulse_done();
        send_box(20, 10, 30, 16);
        drive_frame(20, 48, 1'b1);
        check_eq("cnt_a", 32'(box_count), 32'h1);
        check_px("a_2_2", 2, 2, 1'b1);
        check_px("a_8_5", 8, 5, 1'b1);
        check_px("a_5_5", 5, 5, 1'b0);
        check_px("a_b_20_10", 20, 10, 1'b0);
        drive_frame(20, 48, 1'b0);
        check_px("b_20_10", 20, 10, 1'b1);
        check_px("b_30_16", 30, 16, 1'b1);
        check_px("b_25_13", 25, 13, 1'b0);
        check_px("b_a_2_2", 2, 2, 1'b0);
        check_eq("ovf_sticky", {31'h0, overflow}, 32'h1);

        // Reset in the middle of active video.
        tick();
        de = 1'b1; r = 8'h11; g = 8'h22; b = 8'h33;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_0", {5'h0, de_out, hsync_out, vsync_out, r_out, g_out, b_out}, 32'h0);
        @(negedge clk);
        check_eq("mid_rst_1", {5'h0, de_out, hsync_out, vsync_out, r_out, g_out, b_out}, 32'h0);
        @(negedge clk);
        check_eq("mid_rst_pass", {5'h0, de_out, hsync_out, vsync_out, r_out, g_out, b_out},
                 {5'h0, 3'b100, 24'h112233});
        check_eq("mid_rst_cnt", 32'(box_count), 32'h0);
        check_eq("mid_rst_ovf", {31'h0, overflow}, 32'h0);
        tick();
        idle_inputs();
        drive_frame(20, 48, 1'b0);
        check_px("post_rst_20_10", 20, 10, 1'b0);
        check_px("post_rst_2_2", 2, 2, 1'b0);
        send_box(20, 10, 30, 16);
        pulse_done();
        drive_frame(20, 48, 1'b0);
        check_eq("post_rst_cnt", 32'(box_count), 32'h1);
        check_px("redraw_20_10", 20, 10, 1'b1);
        check_px("redraw_25_13", 25, 13, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
